// File: rtl/svs_monitor_pkg.sv
// rtl/svs_monitor_pkg.sv - shared types, defaults and helpers for the SVS monitor sequencer
package svs_monitor_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ARM  = 3'd1,
        ST_WAIT = 3'd2,
        ST_ACC  = 3'd3,
        ST_REST = 3'd4,
        ST_DONE = 3'd5
    } seq_state_e;

    localparam int NB_MONITOR_DEF   = 30;
    localparam int COUNT_W_DEF      = 16;
    localparam int TARGET_W_DEF     = 16;
    localparam int AVG_LOG2_MAX_DEF = 3;

    function automatic int acc_width(input int count_w, input int avg_log2_max);
        return count_w + avg_log2_max;
    endfunction

endpackage

// File: rtl/svs_monitor_seq_chan.sv
// rtl/svs_monitor_seq_chan.sv - one channel: accumulator, truncated average, alarms, min/max
module svs_monitor_seq_chan
    import svs_monitor_pkg::*;
#(
    parameter int COUNT_W      = COUNT_W_DEF,
    parameter int AVG_LOG2_MAX = AVG_LOG2_MAX_DEF,
    parameter int LOG_W        = $clog2(AVG_LOG2_MAX + 1)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_en,
    input  logic               i_acc_clr,
    input  logic               i_acc_add,
    input  logic               i_done,
    input  logic               i_clear_minmax,
    input  logic [LOG_W-1:0]   i_avg_log2,
    input  logic [COUNT_W-1:0] i_count,
    input  logic [COUNT_W-1:0] i_thr_low,
    input  logic [COUNT_W-1:0] i_thr_high,
    output logic [COUNT_W-1:0] o_avg,
    output logic [COUNT_W-1:0] o_min,
    output logic [COUNT_W-1:0] o_max,
    output logic               o_alarm_low,
    output logic               o_alarm_high
);
    localparam int ACC_W = acc_width(COUNT_W, AVG_LOG2_MAX);

    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [COUNT_W-1:0] avg_q, avg_d, min_q, min_d, max_q, max_d;
    logic               al_q, al_d, ah_q, ah_d;
    logic [COUNT_W-1:0] avg_new, min_base, max_base;

    assign avg_new  = COUNT_W'(acc_q >> i_avg_log2);
    // A clear coinciding with DONE is applied before the new average is folded in.
    assign min_base = i_clear_minmax ? '1 : min_q;
    assign max_base = i_clear_minmax ? '0 : max_q;

    always_comb begin
        acc_d = acc_q;
        if (i_acc_clr) begin
            acc_d = '0;
        end else if (i_acc_add && i_en) begin
            acc_d = acc_q + ACC_W'(i_count);
        end
    end

    always_comb begin
        avg_d = avg_q;
        min_d = min_base;
        max_d = max_base;
        al_d  = al_q;
        ah_d  = ah_q;
        if (i_done) begin
            al_d = i_en && (avg_new < i_thr_low);
            ah_d = i_en && (avg_new > i_thr_high);
            if (i_en) begin
                avg_d = avg_new;
                min_d = (avg_new < min_base) ? avg_new : min_base;
                max_d = (avg_new > max_base) ? avg_new : max_base;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            acc_q <= '0;
            avg_q <= '0;
            min_q <= '1;
            max_q <= '0;
            al_q  <= 1'b0;
            ah_q  <= 1'b0;
        end else begin
            acc_q <= acc_d;
            avg_q <= avg_d;
            min_q <= min_d;
            max_q <= max_d;
            al_q  <= al_d;
            ah_q  <= ah_d;
        end
    end

    // Results are presented during DONE itself so o_done and the new values line up.
    assign o_avg        = i_done ? avg_d : avg_q;
    assign o_min        = i_done ? min_d : min_q;
    assign o_max        = i_done ? max_d : max_q;
    assign o_alarm_low  = i_done ? al_d  : al_q;
    assign o_alarm_high = i_done ? ah_d  : ah_q;

endmodule

// File: rtl/svs_monitor_seq.sv
// rtl/svs_monitor_seq.sv - SVS monitor measurement sequencer: FSM, config latch, edge detect, timeout
module svs_monitor_seq
    import svs_monitor_pkg::*;
#(
    parameter int NB_MONITOR     = NB_MONITOR_DEF,
    parameter int COUNT_W        = COUNT_W_DEF,
    parameter int TARGET_W       = TARGET_W_DEF,
    parameter int AVG_LOG2_MAX   = AVG_LOG2_MAX_DEF,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_start,
    input  logic                          i_continuous,
    input  logic [$clog2(AVG_LOG2_MAX+1)-1:0] i_avg_log2,
    input  logic [TARGET_W-1:0]           i_target,
    input  logic [NB_MONITOR-1:0]         i_use_ro,
    input  logic [COUNT_W-1:0]            i_thr_low,
    input  logic [COUNT_W-1:0]            i_thr_high,
    input  logic                          i_clear_minmax,
    output logic                          o_mon_enable,
    output logic [TARGET_W-1:0]           o_mon_target,
    output logic [NB_MONITOR-1:0]         o_mon_use_ro,
    input  logic                          i_mon_valid,
    input  logic [NB_MONITOR*COUNT_W-1:0] i_mon_count,
    output logic                          o_busy,
    output logic                          o_done,
    output logic                          o_timeout,
    output logic [NB_MONITOR*COUNT_W-1:0] o_avg,
    output logic [NB_MONITOR*COUNT_W-1:0] o_min,
    output logic [NB_MONITOR*COUNT_W-1:0] o_max,
    output logic [NB_MONITOR-1:0]         o_alarm_low,
    output logic [NB_MONITOR-1:0]         o_alarm_high
);
    localparam int LOG_W = $clog2(AVG_LOG2_MAX + 1);
    localparam int TO_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int SMP_W = (AVG_LOG2_MAX > 0) ? AVG_LOG2_MAX : 1;

    seq_state_e                  state_q, state_d;
    logic [LOG_W-1:0]            log2_q, log2_in;
    logic [TARGET_W-1:0]         target_q;
    logic [NB_MONITOR-1:0]       use_ro_q;
    logic [COUNT_W-1:0]          thr_low_q, thr_high_q;
    logic [SMP_W-1:0]            smp_q, smp_last;
    logic [TO_W-1:0]             to_cnt_q;
    logic                        valid_q, timeout_q;
    logic [NB_MONITOR*COUNT_W-1:0] cap_q;
    logic                        latch_cfg, valid_edge, timeout_hit;

    assign log2_in     = (32'(i_avg_log2) > 32'(AVG_LOG2_MAX)) ? LOG_W'(AVG_LOG2_MAX) : i_avg_log2;
    assign latch_cfg   = ((state_q == ST_IDLE) && i_start) || ((state_q == ST_DONE) && i_continuous);
    assign valid_edge  = (state_q == ST_WAIT) && i_mon_valid && !valid_q;
    assign timeout_hit = (state_q == ST_WAIT) && !valid_edge && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
    assign smp_last    = SMP_W'((32'd1 << log2_q) - 32'd1);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (i_start) state_d = ST_ARM;
            ST_ARM:  state_d = ST_WAIT;
            ST_WAIT: begin
                if (valid_edge) begin
                    state_d = ST_ACC;
                end else if (timeout_hit) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACC:  state_d = (smp_q == smp_last) ? ST_DONE : ST_REST;
            ST_REST: state_d = ST_ARM;
            ST_DONE: state_d = i_continuous ? ST_ARM : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        o_busy       = (state_q != ST_IDLE);
        o_mon_enable = (state_q == ST_ARM) || (state_q == ST_WAIT);
        o_done       = (state_q == ST_DONE);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            log2_q     <= '0;
            target_q   <= '0;
            use_ro_q   <= '0;
            thr_low_q  <= '0;
            thr_high_q <= '0;
            smp_q      <= '0;
            to_cnt_q   <= '0;
            valid_q    <= 1'b0;
            timeout_q  <= 1'b0;
            cap_q      <= '0;
        end else begin
            if (latch_cfg) begin
                log2_q     <= log2_in;
                target_q   <= i_target;
                use_ro_q   <= i_use_ro;
                thr_low_q  <= i_thr_low;
                thr_high_q <= i_thr_high;
            end
            // Clearing the edge history in ARM makes every sample wait for a new valid.
            valid_q   <= (state_q == ST_ARM) ? 1'b0 : i_mon_valid;
            to_cnt_q  <= (state_q == ST_WAIT) ? to_cnt_q + 1'b1 : '0;
            timeout_q <= timeout_hit;
            if (valid_edge) begin
                cap_q <= i_mon_count;
            end
            if (state_q == ST_ACC) begin
                smp_q <= smp_q + 1'b1;
            end else if ((state_q == ST_DONE) || (state_q == ST_IDLE)) begin
                smp_q <= '0;
            end
        end
    end

    assign o_timeout    = timeout_q;
    assign o_mon_target = target_q;
    assign o_mon_use_ro = use_ro_q;

    for (genvar c = 0; c < NB_MONITOR; c++) begin : g_chan
        svs_monitor_seq_chan #(
            .COUNT_W      (COUNT_W),
            .AVG_LOG2_MAX (AVG_LOG2_MAX),
            .LOG_W        (LOG_W)
        ) u_chan (
            .i_clk          (i_clk),
            .i_rst          (i_rst),
            .i_en           (use_ro_q[c]),
            .i_acc_clr      ((state_q == ST_ARM) && (smp_q == '0)),
            .i_acc_add      (state_q == ST_ACC),
            .i_done         (state_q == ST_DONE),
            .i_clear_minmax (i_clear_minmax),
            .i_avg_log2     (log2_q),
            .i_count        (cap_q[c*COUNT_W +: COUNT_W]),
            .i_thr_low      (thr_low_q),
            .i_thr_high     (thr_high_q),
            .o_avg          (o_avg[c*COUNT_W +: COUNT_W]),
            .o_min          (o_min[c*COUNT_W +: COUNT_W]),
            .o_max          (o_max[c*COUNT_W +: COUNT_W]),
            .o_alarm_low    (o_alarm_low[c]),
            .o_alarm_high   (o_alarm_high[c])
        );
    end

endmodule

// File: tb/tb_svs_monitor_seq.sv
// tb/tb_svs_monitor_seq.sv - directed self-checking bench for svs_monitor_seq with result scoreboard
module tb_svs_monitor_seq;
    localparam int NB = 8;
    localparam int CW = 16;
    localparam int TW = 16;
    localparam int AM = 3;
    localparam int TO = 16;
    localparam int LW = $clog2(AM + 1);
    localparam int AW = CW + AM;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_start, i_continuous, i_clear_minmax, i_mon_valid;
    logic [LW-1:0]     i_avg_log2;
    logic [TW-1:0]     i_target;
    logic [NB-1:0]     i_use_ro;
    logic [CW-1:0]     i_thr_low, i_thr_high;
    logic [NB*CW-1:0]  i_mon_count;
    logic              o_mon_enable, o_busy, o_done, o_timeout;
    logic [TW-1:0]     o_mon_target;
    logic [NB-1:0]     o_mon_use_ro, o_alarm_low, o_alarm_high;
    logic [NB*CW-1:0]  o_avg, o_min, o_max;

    always #5 clk = ~clk;

    svs_monitor_seq #(
        .NB_MONITOR(NB), .COUNT_W(CW), .TARGET_W(TW), .AVG_LOG2_MAX(AM), .TIMEOUT_CYCLES(TO)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_start(i_start), .i_continuous(i_continuous),
        .i_avg_log2(i_avg_log2), .i_target(i_target), .i_use_ro(i_use_ro),
        .i_thr_low(i_thr_low), .i_thr_high(i_thr_high), .i_clear_minmax(i_clear_minmax),
        .o_mon_enable(o_mon_enable), .o_mon_target(o_mon_target), .o_mon_use_ro(o_mon_use_ro),
        .i_mon_valid(i_mon_valid), .i_mon_count(i_mon_count), .o_busy(o_busy), .o_done(o_done),
        .o_timeout(o_timeout), .o_avg(o_avg), .o_min(o_min), .o_max(o_max),
        .o_alarm_low(o_alarm_low), .o_alarm_high(o_alarm_high)
    );

    typedef struct {
        logic [NB*CW-1:0] avg;
        logic [NB*CW-1:0] mn;
        logic [NB*CW-1:0] mx;
        logic [NB-1:0]    al;
        logic [NB-1:0]    ah;
    } exp_t;

    exp_t             sb[$];
    int               n_assert = 0;
    int               n_fail = 0;
    logic [CW-1:0]    m_avg[NB];
    logic [CW-1:0]    m_min[NB];
    logic [CW-1:0]    m_max[NB];
    logic [AW-1:0]    sum[NB];
    logic [NB-1:0]    c_mask;
    logic [LW-1:0]    c_log2;
    logic [CW-1:0]    c_thl, c_thh;
    logic [NB*CW-1:0] vec;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [NB*CW-1:0] obs, input logic [NB*CW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NB*CW-1:0] fill(input logic [CW-1:0] v);
        logic [NB*CW-1:0] r;
        for (int c = 0; c < NB; c++) r[c*CW +: CW] = v;
        return r;
    endfunction

    function automatic logic [NB*CW-1:0] model_avg();
        logic [NB*CW-1:0] r;
        for (int c = 0; c < NB; c++) r[c*CW +: CW] = m_avg[c];
        return r;
    endfunction

    task automatic reset_model();
        for (int c = 0; c < NB; c++) begin
            m_avg[c] = '0;
            m_min[c] = '1;
            m_max[c] = '0;
        end
        sb.delete();
    endtask

    task automatic clear_minmax_model();
        for (int c = 0; c < NB; c++) begin
            m_min[c] = '1;
            m_max[c] = '0;
        end
    endtask

    task automatic new_sums();
        for (int c = 0; c < NB; c++) sum[c] = '0;
    endtask

    task automatic push_round(input logic clr);
        exp_t          e;
        logic [AW-1:0] sh;
        if (clr) clear_minmax_model();
        for (int c = 0; c < NB; c++) begin
            e.al[c] = 1'b0;
            e.ah[c] = 1'b0;
            if (c_mask[c]) begin
                sh = sum[c] >> c_log2;
                m_avg[c] = sh[CW-1:0];
                if (m_avg[c] < m_min[c]) m_min[c] = m_avg[c];
                if (m_avg[c] > m_max[c]) m_max[c] = m_avg[c];
                e.al[c] = (m_avg[c] < c_thl);
                e.ah[c] = (m_avg[c] > c_thh);
            end
            e.avg[c*CW +: CW] = m_avg[c];
            e.mn[c*CW +: CW]  = m_min[c];
            e.mx[c*CW +: CW]  = m_max[c];
        end
        sb.push_back(e);
    endtask

    task automatic start(input logic [NB-1:0] mask, input logic [LW-1:0] l2,
                         input logic [CW-1:0] thl, input logic [CW-1:0] thh, input logic cont);
        c_mask = mask; c_log2 = l2; c_thl = thl; c_thh = thh;
        i_use_ro = mask; i_avg_log2 = l2; i_thr_low = thl; i_thr_high = thh;
        i_continuous = cont; i_start = 1'b1;
        new_sums();
        tick();
        i_start = 1'b0;
    endtask

    // Leaves the bench in the cycle after ACC: REST, or DONE for the last sample.
    task automatic sample(input logic [NB*CW-1:0] cnt);
        int n;
        n = 0;
        while (o_mon_enable !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("arm_enable", o_mon_enable, 1'b1);
        tick();
        i_mon_valid = 1'b1;
        i_mon_count = cnt;
        for (int c = 0; c < NB; c++)
            if (c_mask[c]) sum[c] = sum[c] + AW'(cnt[c*CW +: CW]);
        tick();
        i_mon_valid = 1'b0;
        check("acc_enable_low", o_mon_enable, 1'b0);
        tick();
    endtask

    task automatic expect_done();
        exp_t e;
        check("done_pulse", o_done, 1'b1);
        check("sb_nonempty", (sb.size() != 0), 1'b1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("avg", o_avg, e.avg);
            check("min", o_min, e.mn);
            check("max", o_max, e.mx);
            check("alarm_low", o_alarm_low, e.al);
            check("alarm_high", o_alarm_high, e.ah);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic saw_done;
        rst = 1'b1; i_start = 0; i_continuous = 0; i_clear_minmax = 0; i_mon_valid = 0;
        i_avg_log2 = '0; i_target = '0; i_use_ro = '0; i_thr_low = '0; i_thr_high = '0;
        i_mon_count = '0;
        reset_model();
        new_sums();
        #2;
        check("rst_busy", o_busy, 1'b0);
        check("rst_enable", o_mon_enable, 1'b0);
        check("rst_done", o_done, 1'b0);
        check("rst_timeout", o_timeout, 1'b0);
        check("rst_avg", o_avg, '0);
        check("rst_min", o_min, {NB*CW{1'b1}});
        check("rst_max", o_max, '0);
        check("rst_alarms", {o_alarm_low, o_alarm_high}, '0);
        check("rst_use_ro", o_mon_use_ro, '0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Single round, four samples on channel 0; later input changes must not leak in.
        i_target = 16'h1234;
        start(8'h01, 2'd2, 16'd0, 16'hFFFF, 1'b0);
        check("start_busy", o_busy, 1'b1);
        check("start_enable", o_mon_enable, 1'b1);
        check("latched_target", o_mon_target, 16'h1234);
        i_use_ro = '1; i_target = '0;
        check("latched_use_ro", o_mon_use_ro, 8'h01);
        vec = fill(16'd500); vec[15:0] = 16'd100; sample(vec);
        vec[15:0] = 16'd101; sample(vec);
        vec[15:0] = 16'd102; sample(vec);
        vec[15:0] = 16'd105; sample(vec);
        push_round(1'b0);
        expect_done();
        check("t1_avg0", o_avg[15:0], 16'd102);
        tick();
        check("t1_busy_drop", o_busy, 1'b0);
        check("t1_done_once", o_done, 1'b0);
        check("t1_hold", o_avg[15:0], 16'd102);

        // Threshold alarms with channel 5 masked.
        start(8'hDF, 2'd1, 16'd50, 16'd200, 1'b0);
        vec = fill(16'd100); vec[3*CW +: CW] = 16'd39; vec[4*CW +: CW] = 16'd249;
        vec[5*CW +: CW] = 16'd300; sample(vec);
        vec[3*CW +: CW] = 16'd41; vec[4*CW +: CW] = 16'd251; sample(vec);
        push_round(1'b0);
        expect_done();
        check("t2_alarm_low", o_alarm_low, 8'h08);
        check("t2_alarm_high", o_alarm_high, 8'h10);
        check("t2_masked_avg", o_avg[5*CW +: CW], 16'd0);
        tick();

        // Clear min/max while idle, then continuous rounds 90, 120, 80.
        i_clear_minmax = 1'b1;
        clear_minmax_model();
        tick();
        i_clear_minmax = 1'b0;
        check("idle_clear_min", o_min[15:0], 16'hFFFF);
        check("idle_clear_max", o_max[15:0], 16'd0);
        start(8'h01, 2'd1, 16'd0, 16'hFFFF, 1'b1);
        for (int r = 0; r < 3; r++) begin
            logic [CW-1:0] v;
            v = (r == 0) ? 16'd90 : (r == 1) ? 16'd120 : 16'd80;
            new_sums();
            vec = fill(v - 16'd1); sample(vec);
            vec = fill(v + 16'd1); sample(vec);
            push_round(1'b0);
            expect_done();
            tick();
            check("cont_rearm", o_mon_enable, 1'b1);
        end
        check("cont_min", o_min[15:0], 16'd80);
        check("cont_max", o_max[15:0], 16'd120);
        new_sums();
        vec = fill(16'd99); sample(vec);
        i_continuous = 1'b0;
        vec = fill(16'd101); sample(vec);
        i_clear_minmax = 1'b1;
        #1;
        push_round(1'b1);
        expect_done();
        check("clr_done_min", o_min[15:0], 16'd100);
        check("clr_done_max", o_max[15:0], 16'd100);
        tick();
        i_clear_minmax = 1'b0;
        check("cont_stop_idle", o_busy, 1'b0);
        check("clr_hold_min", o_min[15:0], 16'd100);

        // Timeout: valid never rises.
        start(8'h01, 2'd0, 16'd0, 16'hFFFF, 1'b0);
        tick();
        saw_done = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            saw_done = saw_done | o_done;
        end
        check("to_not_yet", o_timeout, 1'b0);
        check("to_still_busy", o_busy, 1'b1);
        tick();
        check("to_pulse", o_timeout, 1'b1);
        check("to_idle", o_busy, 1'b0);
        tick();
        check("to_single", o_timeout, 1'b0);
        check("to_avg_hold", o_avg, model_avg());
        check("to_no_done", saw_done, 1'b0);

        // Largest encodable average request: eight full-scale samples.
        start(8'hFF, 2'd3, 16'd0, 16'hFFFE, 1'b0);
        for (int s = 0; s < 7; s++) begin
            sample(fill(16'hFFFF));
            check("ovf_no_early_done", o_done, 1'b0);
        end
        sample(fill(16'hFFFF));
        push_round(1'b0);
        expect_done();
        check("ovf_avg0", o_avg[15:0], 16'hFFFF);
        tick();

        // Asynchronous reset in WAIT of the second sample, then a clean round.
        start(8'h01, 2'd1, 16'd0, 16'hFFFF, 1'b0);
        sample(fill(16'd50));
        tick();
        tick();
        check("pre_rst_wait", o_mon_enable, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        reset_model();
        check("arst_enable", o_mon_enable, 1'b0);
        check("arst_busy", o_busy, 1'b0);
        check("arst_avg", o_avg, '0);
        check("arst_min", o_min, {NB*CW{1'b1}});
        check("arst_max", o_max, '0);
        tick();
        rst = 1'b0;
        tick();
        start(8'h01, 2'd1, 16'd0, 16'hFFFF, 1'b0);
        sample(fill(16'd60));
        sample(fill(16'd70));
        push_round(1'b0);
        expect_done();
        check("post_rst_avg0", o_avg[15:0], 16'd65);
        tick();
        check("post_rst_idle", o_busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
